// File: rtl/fb_rect_fill.sv
// fb_rect_fill: walks a clipped rectangle in row-major order and emits one
// pixel write (x_pos, y_pos, color, en) per cycle while the framebuffer is ready.
module fb_rect_fill #(
  parameter int H_RES = 640,
  parameter int V_RES = 400
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [9:0] cmd_x0,
  input  logic [9:0] cmd_y0,
  input  logic [9:0] cmd_w,
  input  logic [9:0] cmd_h,
  input  logic [3:0] cmd_color,
  input  logic       fb_ready,
  output logic [9:0] x_pos,
  output logic [9:0] y_pos,
  output logic [3:0] color,
  output logic       en,
  output logic       busy,
  output logic       done
);

  localparam logic [10:0] LP_H = 11'(H_RES);
  localparam logic [10:0] LP_V = 11'(V_RES);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FILL,
    S_DONE
  } state_t;

  state_t      r_state;
  state_t      w_next;

  logic [9:0]  r_x0;
  logic [10:0] r_x_end;
  logic [10:0] r_y_end;
  logic [3:0]  r_color;
  logic [9:0]  r_cx;
  logic [9:0]  r_cy;

  logic [10:0] w_x_sum;
  logic [10:0] w_y_sum;
  logic [10:0] w_x_end_cmd;
  logic [10:0] w_y_end_cmd;
  logic        w_empty;
  logic        w_accept;
  logic        w_load;

  logic [9:0]  w_bx0;
  logic [10:0] w_bxe;
  logic [10:0] w_bye;
  logic [9:0]  w_px;
  logic [9:0]  w_py;
  logic [3:0]  w_pcolor;
  logic        w_row_end;
  logic        w_last;

  logic        w_emit;
  logic [9:0]  w_cx_nxt;
  logic [9:0]  w_cy_nxt;
  logic        w_ready_nxt;

  // Command decode: clipped bounds at 11 bits and emptiness test.
  always_comb begin
    w_x_sum     = {1'b0, cmd_x0} + {1'b0, cmd_w};
    w_y_sum     = {1'b0, cmd_y0} + {1'b0, cmd_h};
    w_x_end_cmd = (w_x_sum > LP_H) ? LP_H : w_x_sum;
    w_y_end_cmd = (w_y_sum > LP_V) ? LP_V : w_y_sum;
    w_empty     = (cmd_w == '0) || (cmd_h == '0) ||
                  ({1'b0, cmd_x0} >= LP_H) || ({1'b0, cmd_y0} >= LP_V);
    w_accept    = cmd_valid && cmd_ready && (r_state == S_IDLE);
    w_load      = w_accept && !w_empty;
  end

  // Current pixel and bounds: on the accept edge they come straight from the
  // command so the first pixel can be written on that same edge; otherwise
  // from the latched copies.
  always_comb begin
    w_bx0     = w_load ? cmd_x0      : r_x0;
    w_bxe     = w_load ? w_x_end_cmd : r_x_end;
    w_bye     = w_load ? w_y_end_cmd : r_y_end;
    w_px      = w_load ? cmd_x0      : r_cx;
    w_py      = w_load ? cmd_y0      : r_cy;
    w_pcolor  = w_load ? cmd_color   : r_color;
    w_row_end = (({1'b0, w_px} + 11'd1) == w_bxe);
    w_last    = w_row_end && (({1'b0, w_py} + 11'd1) == w_bye);
  end

  // Next-state, pixel emit and cursor advance.
  // A one-pixel command written on the accept edge goes straight to DONE,
  // since FILL would have nothing left to do.
  always_comb begin
    w_next   = r_state;
    w_emit   = 1'b0;
    w_cx_nxt = r_cx;
    w_cy_nxt = r_cy;
    case (r_state)
      S_IDLE: if (w_accept) w_next = w_empty ? S_DONE : S_FILL;
      S_FILL: w_next = S_FILL;
      S_DONE: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
    if (w_load || (r_state == S_FILL)) begin
      w_cx_nxt = w_px;
      w_cy_nxt = w_py;
      if (fb_ready) begin
        w_emit = 1'b1;
        if (w_last) begin
          w_next = S_DONE;
        end else if (w_row_end) begin
          w_cx_nxt = w_bx0;
          w_cy_nxt = w_py + 10'd1;
        end else begin
          w_cx_nxt = w_px + 10'd1;
        end
      end
    end
    w_ready_nxt = (r_state == S_IDLE) && !w_accept;
  end

  // State, command latches, cursor and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_x0      <= '0;
      r_x_end   <= '0;
      r_y_end   <= '0;
      r_color   <= '0;
      r_cx      <= '0;
      r_cy      <= '0;
      cmd_ready <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      en        <= 1'b0;
      x_pos     <= '0;
      y_pos     <= '0;
      color     <= '0;
    end else begin
      r_state <= w_next;
      r_cx    <= w_cx_nxt;
      r_cy    <= w_cy_nxt;
      if (w_accept) begin
        r_x0    <= cmd_x0;
        r_x_end <= w_x_end_cmd;
        r_y_end <= w_y_end_cmd;
        r_color <= cmd_color;
      end
      cmd_ready <= w_ready_nxt;
      busy      <= !w_ready_nxt;
      done      <= (r_state == S_DONE);
      en        <= w_emit;
      if (w_emit) begin
        x_pos <= w_px;
        y_pos <= w_py;
        color <= w_pcolor;
      end
    end
  end

endmodule

// File: doc/fb_rect_fill.md
FB_RECT_FILL -- requirements
Module: fb_rect_fill

Interface
REQ-001 Parameter H_RES, default 640, framebuffer width in pixels.
REQ-002 Parameter V_RES, default 400, framebuffer height in pixels.
REQ-003 clk  input  1  display clock; all logic in this single clock domain.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 cmd_valid  input  1  rectangle command present.
REQ-006 cmd_ready  output  1  block can accept a command.
REQ-007 cmd_x0  input  10  left column.
REQ-008 cmd_y0  input  10  top row.
REQ-009 cmd_w  input  10  width in pixels.
REQ-010 cmd_h  input  10  height in pixels.
REQ-011 cmd_color  input  4  fill colour index.
REQ-012 fb_ready  input  1  framebuffer ready for writes.
REQ-013 x_pos  output  10  pixel column to xy_to_addr.
REQ-014 y_pos  output  10  pixel row to xy_to_addr.
REQ-015 color  output  4  pixel colour to xy_to_addr.
REQ-016 en  output  1  pixel write strobe; x_pos, y_pos and color are valid when en is high.
REQ-017 busy  output  1  command in progress.
REQ-018 done  output  1  single-cycle pulse when a command completes.

Function
REQ-019 The block SHALL implement states IDLE, FILL and DONE.
REQ-020 cmd_ready SHALL be high only in IDLE; a command SHALL be accepted on the edge where cmd_valid and cmd_ready are both high.
REQ-021 On acceptance, the block SHALL latch colour and clipped bounds: x_end = min(x0+w, H_RES) and y_end = min(y0+h, V_RES), computed at 11 bits with no wrap.
REQ-022 An empty command SHALL go IDLE->DONE with no en pulses; a command is empty if w==0, h==0, x0>=H_RES or y0>=V_RES.
REQ-023 A non-empty command SHALL go IDLE->FILL, with the internal cursor set to (x0, y0).
REQ-024 In FILL, for each cycle where fb_ready is high, the block SHALL drive en=1 with the cursor on x_pos/y_pos and the latched colour, then advance the cursor.
REQ-025 The scan order SHALL be row-major: x increments; when x reaches x_end-1, x returns to x0 and y increments.
REQ-026 In FILL with fb_ready low, en SHALL be 0 and the cursor SHALL hold, so no pixel is skipped or repeated.
REQ-027 All outputs SHALL be registered; the first en cycle SHALL be the cycle after acceptance, when fb_ready is high.
REQ-028 After the en cycle for pixel (x_end-1, y_end-1), the block SHALL enter DONE.
REQ-029 DONE SHALL last exactly one cycle with done=1, then return to IDLE.
REQ-030 busy SHALL be high in FILL and DONE.
REQ-031 The number of en pulses per command SHALL equal (x_end-x0)*(y_end-y0).
REQ-032 cmd_* changes after acceptance SHALL NOT affect the command in progress.
REQ-033 When en is low, x_pos, y_pos and color SHALL hold their last values.

Reset
REQ-034 While reset is high, the block SHALL enter IDLE with en=0, done=0, busy=0, x_pos=0, y_pos=0 and color=0; cmd_ready SHALL be 0 while reset is asserted and 1 afterwards.
REQ-035 Reset asserted mid-FILL SHALL abort the command on the next edge: no further en pulses and no done pulse.
REQ-036 Reset SHALL take priority over a simultaneous command acceptance.

Verification
REQ-037 Command (320,0,8,400,colour 1) with fb_ready held high -> 3200 en pulses, row-major from (320,0) to (327,399), all colour 1; first en one cycle after acceptance; done one cycle after the last en.
REQ-038 Command (636,398,10,10,colour 5) -> clipped to x 636..639, y 398..399; exactly 8 en pulses; done pulses.
REQ-039 Commands with w=0, and separately x0=640 -> zero en pulses; done exactly two cycles after acceptance; cmd_ready back high one cycle later.
REQ-040 Command (0,0,3,2,colour 2) with fb_ready toggling every cycle -> exactly 6 en pulses, each coordinate exactly once, in order (0,0),(1,0),(2,0),(0,1),(1,1),(2,1).
REQ-041 Reset pulsed after the 5th en of a 4x4 command -> no further en, no done, cmd_ready=1 after reset deasserts; a following 1x1 command completes normally.
REQ-042 cmd_valid held high continuously with back-to-back commands -> cmd_ready low throughout FILL and DONE; the second command is accepted in the first IDLE cycle after done.
